// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag bundle, FSM states and
// the shifter sub-op encoding (which matches the low two opcode bits).
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_RSB  = 4'h2,
      ALU_BIC  = 4'h3,
      ALU_AND  = 4'h4,
      ALU_ORR  = 4'h5,
      ALU_EOR  = 4'h6,
      ALU_XNOR = 4'h7,
      ALU_LSL  = 4'h8,
      ALU_LSR  = 4'h9,
      ALU_ASR  = 4'hA,
      ALU_ROR  = 4'hB,
      ALU_MUL  = 4'hC
   } alu_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } alu_state_e;

   localparam alu_flags_t FLAGS_RST = '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};

   localparam logic [1:0] SH_LSL = 2'd0;
   localparam logic [1:0] SH_LSR = 2'd1;
   localparam logic [1:0] SH_ASR = 2'd2;
   localparam logic [1:0] SH_ROR = 2'd3;

endpackage

// File: rtl/alu_shifter.sv
// Combinational log-stage barrel shifter (LSL/LSR/ASR/ROR) with the carry of
// the last bit shifted out and a zero-amount indication.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [SHW-1:0]   amt,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             amt_zero
);

   localparam logic [SHW-1:0] ONE = SHW'(1);

   logic [WIDTH-1:0] stage [0:SHW];
   logic [SHW-1:0]   out_idx;

   assign stage[0] = data;

   genvar gi;
   generate
      for (gi = 0; gi < SHW; gi++) begin : g_stage
         localparam int S = 1 << gi;
         logic [WIDTH-1:0] shifted;

         always_comb begin
            case (op)
               SH_LSL:  shifted = stage[gi] << S;
               SH_LSR:  shifted = stage[gi] >> S;
               SH_ASR:  shifted = $signed(stage[gi]) >>> S;
               default: shifted = (stage[gi] >> S) | (stage[gi] << (WIDTH - S));
            endcase
         end

         assign stage[gi+1] = amt[gi] ? shifted : stage[gi];
      end
   endgenerate

   // Last bit out: data[WIDTH-amt] for a left shift, data[amt-1] otherwise.
   assign out_idx   = (op == SH_LSL) ? (~amt + ONE) : (amt - ONE);
   assign carry_out = data[out_idx];
   assign amt_zero  = (amt == '0);
   assign result    = stage[SHW];

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready input, persistent NZCV flags and an
// iterative shift-add multiplier that occupies the unit for WIDTH cycles.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ctrl,
   input  logic             set_flags,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic [WIDTH-1:0] Y,
   output logic             out_valid,
   output logic             N,
   output logic             Z,
   output logic             CO,
   output logic             OVF
);

   localparam int             MSB  = WIDTH - 1;
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
   localparam logic [SHW-1:0] ONE  = SHW'(1);

   alu_state_e state_reg, state_next;
   alu_flags_t flags_reg, flags_next;
   logic [WIDTH-1:0] y_reg, y_next;
   logic             out_valid_reg, out_valid_next;

   logic [WIDTH-1:0] mcand_reg, mplier_reg, acc_reg, acc_sum;
   logic [SHW-1:0]   cnt_reg;
   logic             mul_sf_reg;

   logic accept, start_mul, op_done, mul_step, mul_done;

   // Add/sub share one adder: SUB/RSB feed the inverted subtrahend plus carry-in.
   logic [WIDTH-1:0] add_x, add_y;
   logic             add_cin, add_v;
   logic [WIDTH:0]   sum;

   always_comb begin
      add_x   = A;
      add_y   = ~B;
      add_cin = 1'b1;
      case (ctrl)
         ALU_ADD: begin
            add_y   = B;
            add_cin = 1'b0;
         end
         ALU_RSB: begin
            add_x = B;
            add_y = ~A;
         end
         default: ;
      endcase
   end

   assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
   assign add_v = (add_x[MSB] == add_y[MSB]) & (sum[MSB] != add_x[MSB]);

   logic [WIDTH-1:0] sh_result;
   logic             sh_carry, sh_zero;

   alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
      .data      (A),
      .amt       (B[SHW-1:0]),
      .op        (ctrl[1:0]),
      .result    (sh_result),
      .carry_out (sh_carry),
      .amt_zero  (sh_zero)
   );

   logic [WIDTH-1:0] op_res;
   logic             op_c, op_v;

   always_comb begin
      op_res = '0;
      op_c   = flags_reg.c;
      op_v   = flags_reg.v;
      case (ctrl)
         ALU_ADD, ALU_SUB, ALU_RSB: begin
            op_res = sum[MSB:0];
            op_c   = sum[WIDTH];
            op_v   = add_v;
         end
         ALU_BIC:  op_res = A & ~B;
         ALU_AND:  op_res = A & B;
         ALU_ORR:  op_res = A | B;
         ALU_EOR:  op_res = A ^ B;
         ALU_XNOR: op_res = ~(A ^ B);
         ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROR: begin
            op_res = sh_result;
            op_c   = sh_zero ? flags_reg.c : sh_carry;
         end
         default: op_res = '0;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start_mul) state_next = ST_BUSY;
         ST_BUSY: if (flush || cnt_reg == LAST) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM: outputs and control strobes
   always_comb begin
      in_ready  = (state_reg == ST_IDLE) & ~flush & ~rst;
      accept    = in_valid & in_ready;
      start_mul = accept & (ctrl == ALU_MUL);
      op_done   = accept & (ctrl != ALU_MUL);
      mul_step  = (state_reg == ST_BUSY) & ~flush;
      mul_done  = mul_step & (cnt_reg == LAST);
   end

   assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         mul_sf_reg <= 1'b0;
      end else if (start_mul) begin
         mcand_reg  <= A;
         mplier_reg <= B;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         mul_sf_reg <= set_flags;
      end else if (mul_step) begin
         acc_reg    <= acc_sum;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         cnt_reg    <= cnt_reg + ONE;
      end
   end

   always_comb begin
      y_next         = y_reg;
      flags_next     = flags_reg;
      out_valid_next = 1'b0;
      if (op_done) begin
         y_next         = op_res;
         out_valid_next = 1'b1;
         if (set_flags)
            flags_next = '{n: op_res[MSB], z: (op_res == '0), c: op_c, v: op_v};
      end else if (mul_done) begin
         y_next         = acc_sum;
         out_valid_next = 1'b1;
         if (mul_sf_reg)
            flags_next = '{n: acc_sum[MSB], z: (acc_sum == '0), c: flags_reg.c, v: flags_reg.v};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_reg         <= '0;
         out_valid_reg <= 1'b0;
         flags_reg     <= FLAGS_RST;
      end else begin
         y_reg         <= y_next;
         out_valid_reg <= out_valid_next;
         flags_reg     <= flags_next;
      end
   end

   assign Y         = y_reg;
   assign out_valid = out_valid_reg;
   assign N         = flags_reg.n;
   assign Z         = flags_reg.z;
   assign CO        = flags_reg.c;
   assign OVF       = flags_reg.v;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench: a 32-bit unit against an arithmetic reference model
// (directed + random) and an 8-bit unit for multiply latency, flush and reset.
module tb_alu_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready, set_flags, flush, out_valid, N, Z, CO, OVF;
   logic [3:0]  ctrl;
   logic [31:0] A, B, Y;

   logic        rst8, in_valid8, in_ready8, set_flags8, flush8, out_valid8, N8, Z8, CO8, OVF8;
   logic [3:0]  ctrl8;
   logic [7:0]  A8, B8, Y8;

   alu_mc #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
      .set_flags(set_flags), .A(A), .B(B), .flush(flush), .Y(Y), .out_valid(out_valid),
      .N(N), .Z(Z), .CO(CO), .OVF(OVF)
   );

   alu_mc #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .ctrl(ctrl8),
      .set_flags(set_flags8), .A(A8), .B(B8), .flush(flush8), .Y(Y8), .out_valid(out_valid8),
      .N(N8), .Z(Z8), .CO(CO8), .OVF(OVF8)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   logic        mn, mz, mc, mv;
   logic        pend;
   logic [31:0] exp_y;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: result and NZCV from plain wide/signed arithmetic.
   task automatic model_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input bit sf, output logic [31:0] y);
      longint sa, sb, sr;
      logic [32:0] wide;
      int n;
      logic cn, vn;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sr = 0;
      n  = int'(b[4:0]);
      cn = mc;
      vn = mv;
      case (c)
         4'h0: begin
            wide = {1'b0, a} + {1'b0, b};
            y = wide[31:0]; cn = wide[32]; sr = sa + sb;
            vn = (sr != longint'($signed(y)));
         end
         4'h1: begin y = a - b; cn = (a >= b); sr = sa - sb; vn = (sr != longint'($signed(y))); end
         4'h2: begin y = b - a; cn = (b >= a); sr = sb - sa; vn = (sr != longint'($signed(y))); end
         4'h3: y = a & ~b;
         4'h4: y = a & b;
         4'h5: y = a | b;
         4'h6: y = a ^ b;
         4'h7: y = ~(a ^ b);
         4'h8: begin y = a << n; if (n != 0) cn = a[32-n]; end
         4'h9: begin y = a >> n; if (n != 0) cn = a[n-1]; end
         4'hA: begin y = $signed(a) >>> n; if (n != 0) cn = a[n-1]; end
         4'hB: begin y = (a >> n) | (a << (32 - n)); if (n != 0) cn = y[31]; end
         default: y = 32'h0;
      endcase
      if (sf) begin
         mn = y[31]; mz = (y == 32'h0); mc = cn; mv = vn;
      end
   endtask

   // One clock: check the result due from the previous accept, then drive this cycle.
   task automatic cyc(input bit v, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input bit sf);
      logic [31:0] y;
      @(negedge clk);
      chk("out_valid", {31'b0, out_valid}, {31'b0, pend});
      if (pend) chk("Y", Y, exp_y);
      chk("flags", {28'b0, N, Z, CO, OVF}, {28'b0, mn, mz, mc, mv});
      in_valid = v; ctrl = c; A = a; B = b; set_flags = sf;
      pend = 1'b0;
      if (v) begin
         chk("in_ready", {31'b0, in_ready}, 32'd1);
         model_op(c, a, b, sf, y);
         exp_y = y;
         pend  = 1'b1;
      end
      @(posedge clk);
   endtask

   task automatic op_chk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit sf, input logic [31:0] ey, input logic [3:0] ef);
      cyc(1'b1, c, a, b, sf);
      cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("dir_Y", Y, ey);
      chk("dir_flags", {28'b0, N, Z, CO, OVF}, {28'b0, ef});
   endtask

   task automatic mul32(input logic [31:0] a, input logic [31:0] b, input bit sf);
      logic [31:0] y;
      int lat;
      cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
      in_valid = 1'b1; ctrl = 4'hC; A = a; B = b; set_flags = sf;
      chk("mul_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         chk("busy_ready", {31'b0, in_ready}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk("mul32_latency", lat, 32);
      y = a * b;
      chk("mul32_Y", Y, y);
      if (sf) begin mn = y[31]; mz = (y == 32'h0); end
      chk("mul32_flags", {28'b0, N, Z, CO, OVF}, {28'b0, mn, mz, mc, mv});
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic op8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ey, input logic [3:0] ef);
      @(negedge clk);
      in_valid8 = 1'b1; ctrl8 = c; A8 = a; B8 = b; set_flags8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      chk("op8_out_valid", {31'b0, out_valid8}, 32'd1);
      chk("op8_Y", {24'b0, Y8}, {24'b0, ey});
      chk("op8_flags", {28'b0, N8, Z8, CO8, OVF8}, {28'b0, ef});
   endtask

   task automatic mul8_accept(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      in_valid8 = 1'b1; ctrl8 = 4'hC; A8 = a; B8 = b; set_flags8 = 1'b1;
      chk("mul8_in_ready", {31'b0, in_ready8}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
   endtask

   task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ey,
                       input logic [3:0] ef);
      int lat, rdy_low;
      mul8_accept(a, b);
      lat = 0;
      rdy_low = 0;
      while (!out_valid8 && lat < 20) begin
         if (!in_ready8) rdy_low++;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk("mul8_latency", lat, 8);
      chk("mul8_ready_low", rdy_low, 8);
      chk("mul8_ready_back", {31'b0, in_ready8}, 32'd1);
      chk("mul8_Y", {24'b0, Y8}, {24'b0, ey});
      chk("mul8_flags", {28'b0, N8, Z8, CO8, OVF8}, {28'b0, ef});
      @(negedge clk);
      chk("mul8_pulse_width", {31'b0, out_valid8}, 32'd0);
   endtask

   task automatic quiet8(input string tag);
      int pulses;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid8) pulses++;
      end
      chk(tag, pulses, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; ctrl = 4'h0; A = '0; B = '0; set_flags = 1'b0; flush = 1'b0;
      rst8 = 1'b1; in_valid8 = 1'b0; ctrl8 = 4'h0; A8 = '0; B8 = '0; set_flags8 = 1'b0; flush8 = 1'b0;
      mn = 1'b0; mz = 1'b1; mc = 1'b0; mv = 1'b0;
      pend = 1'b0; exp_y = '0;

      repeat (2) @(negedge clk);
      chk("rst_Y", Y, 32'h0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_flags", {28'b0, N, Z, CO, OVF}, 32'h4);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst8_flags", {28'b0, N8, Z8, CO8, OVF8}, 32'h4);
      rst = 1'b0; rst8 = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      op_chk(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110);
      op_chk(4'h1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0011);
      op_chk(4'h4, 32'h0000_000F, 32'h0000_00F0, 1'b1, 32'h0000_0000, 4'b0111);
      op_chk(4'h9, 32'h0000_0003, 32'd1,         1'b1, 32'h0000_0001, 4'b0011);
      op_chk(4'hA, 32'h8000_0000, 32'd31,        1'b1, 32'hFFFF_FFFF, 4'b1001);
      op_chk(4'hB, 32'h0000_0001, 32'd1,         1'b1, 32'h8000_0000, 4'b1011);
      op_chk(4'h8, 32'h0000_0005, 32'd0,         1'b1, 32'h0000_0005, 4'b0011);
      op_chk(4'hD, 32'h1234_5678, 32'h1,         1'b1, 32'h0000_0000, 4'b0111);

      // Back-to-back stream, flags must not move on the second op.
      cyc(1'b1, 4'h0, 32'h7FFF_FFFF, 32'h1, 1'b1);
      cyc(1'b1, 4'h1, 32'h5, 32'h7, 1'b0);
      cyc(1'b1, 4'h6, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1);
      cyc(1'b1, 4'h2, 32'h3, 32'h10, 1'b1);
      cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

      // Flush while idle blocks acceptance.
      cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; ctrl = 4'h0; A = 32'h1; B = 32'h1; set_flags = 1'b1;
      #1;
      chk("flush_idle_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("flush_idle_no_out", {31'b0, out_valid}, 32'd0);
      flush = 1'b0; in_valid = 1'b0;

      mul32(32'd123_457, 32'd98_765, 1'b1);
      for (int i = 0; i < 60; i++) begin
         logic [3:0] c;
         c = 4'($urandom_range(0, 15));
         if (c == 4'hC) mul32(pick(), pick(), 1'($urandom_range(0, 1)));
         else cyc(1'b1, c, pick(), pick(), 1'($urandom_range(0, 1)));
      end
      cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

      // 8-bit unit: multiply keeps C/V from the preceding add.
      op8(4'h0, 8'h80, 8'h80, 8'h00, 4'b0111);
      mul8(8'd13, 8'd11, 8'h8F, 4'b1011);
      mul8(8'd16, 8'd16, 8'h00, 4'b0111);

      mul8_accept(8'd3, 8'd5);
      @(negedge clk);
      @(negedge clk);
      flush8 = 1'b1;
      @(negedge clk);
      flush8 = 1'b0;
      #1;
      chk("flush_ready", {31'b0, in_ready8}, 32'd1);
      chk("flush_out_valid", {31'b0, out_valid8}, 32'd0);
      chk("flush_Y", {24'b0, Y8}, 32'h0);
      chk("flush_flags", {28'b0, N8, Z8, CO8, OVF8}, 32'h7);
      quiet8("flush_no_pulse");

      op8(4'h0, 8'h20, 8'h22, 8'h42, 4'b0000);
      mul8_accept(8'd13, 8'd11);
      @(negedge clk);
      @(negedge clk);
      rst8 = 1'b1;
      #1;
      chk("rst_mid_Y", {24'b0, Y8}, 32'h0);
      chk("rst_mid_out_valid", {31'b0, out_valid8}, 32'd0);
      chk("rst_mid_flags", {28'b0, N8, Z8, CO8, OVF8}, 32'h4);
      chk("rst_mid_ready", {31'b0, in_ready8}, 32'd0);
      @(negedge clk);
      rst8 = 1'b0;
      #1;
      chk("rst_release_ready", {31'b0, in_ready8}, 32'd1);
      quiet8("rst_no_pulse");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
